// File: rtl/mult_pkg.sv
// Shared types and the extend / multiply / half-select / overflow helper for mult_pipe_hs.
// Structs are sized for the widest supported configuration; instances use the low bits.
package mult_pkg;

  localparam int unsigned MaxDataLen = 64;
  localparam int unsigned MaxTagLen  = 16;

  typedef struct packed {
    logic [MaxDataLen-1:0] a;
    logic [MaxDataLen-1:0] b;
    logic                  signed_mode;
    logic                  high_sel;
    logic [MaxTagLen-1:0]  tag;
  } mult_op_t;

  typedef struct packed {
    logic [MaxDataLen-1:0] result;
    logic                  ovf;
    logic [MaxTagLen-1:0]  tag;
  } mult_res_t;

  // dlen is the live operand width; bits of op.a/op.b at or above dlen are ignored.
  function automatic mult_res_t mult_sel(input mult_op_t op, input int dlen);
    logic [MaxDataLen-1:0]          mask;
    logic [MaxDataLen-1:0]          top;
    logic                           a_sign;
    logic                           b_sign;
    logic signed [2*MaxDataLen+1:0] a_w;
    logic signed [2*MaxDataLen+1:0] b_w;
    logic signed [2*MaxDataLen+1:0] prod;
    logic [MaxDataLen-1:0]          lo;
    logic [MaxDataLen-1:0]          hi;
    logic [MaxDataLen-1:0]          exp_hi;
    mult_res_t                      res;
    for (int i = 0; i < int'(MaxDataLen); i++) begin
      mask[i] = (i < dlen);
      top[i]  = (i == dlen - 1);
    end
    a_sign = op.signed_mode & (|(op.a & top));
    b_sign = op.signed_mode & (|(op.b & top));
    a_w = {(2*MaxDataLen+2){a_sign}};
    b_w = {(2*MaxDataLen+2){b_sign}};
    for (int i = 0; i < int'(MaxDataLen); i++) begin
      if (i < dlen) begin
        a_w[i] = op.a[i];
        b_w[i] = op.b[i];
      end
    end
    prod   = a_w * b_w;
    lo     = prod[MaxDataLen-1:0] & mask;
    hi     = MaxDataLen'(prod >> dlen) & mask;
    exp_hi = (op.signed_mode && (|(lo & top))) ? mask : '0;
    res.result = op.high_sel ? hi : lo;
    res.ovf    = !op.high_sel && (hi != exp_hi);
    res.tag    = op.tag;
    return res;
  endfunction

endpackage

// File: rtl/mult_slot.sv
// One pipeline slot: valid bit plus payload, loads from upstream whenever it is empty or
// its current contents are being taken downstream.
module mult_slot
  import mult_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [Width-1:0] up_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [Width-1:0] down_data
);

  logic             valid_q;
  logic [Width-1:0] data_q;

  assign up_ready   = !valid_q || down_ready;
  assign down_valid = valid_q;
  assign down_data  = data_q;

  // Taking a bubble from upstream empties the slot, so bubbles collapse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (up_ready) begin
      valid_q <= up_valid;
      if (up_valid) begin
        data_q <= up_data;
      end
    end
  end

endmodule

// File: rtl/mult_pipe_hs.sv
// Pipelined signed/unsigned multiplier with valid/ready on both sides; the product is formed
// ahead of slot S1 and later slots only delay it.
module mult_pipe_hs
  import mult_pkg::*;
#(
  parameter int unsigned DATA_LEN       = 32,
  parameter int unsigned PIPELINE_STAGE = 3,
  parameter int unsigned TAG_LEN        = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DATA_LEN-1:0]                   in_a,
  input  logic [DATA_LEN-1:0]                   in_b,
  input  logic                                  in_signed,
  input  logic                                  in_high,
  input  logic [TAG_LEN-1:0]                    in_tag,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_LEN-1:0]                   out_result,
  output logic                                  out_ovf,
  output logic [TAG_LEN-1:0]                    out_tag,
  output logic [$clog2(PIPELINE_STAGE+1)-1:0]   inflight
);

  localparam int unsigned PayW = DATA_LEN + 1 + TAG_LEN;
  localparam int unsigned CntW = $clog2(PIPELINE_STAGE + 1);

  mult_op_t        op;
  mult_res_t       res;
  logic [PayW-1:0] in_pay;
  logic            unused_res_bits;

  always_comb begin
    op                     = '0;
    op.a[DATA_LEN-1:0]     = in_a;
    op.b[DATA_LEN-1:0]     = in_b;
    op.signed_mode         = in_signed;
    op.high_sel            = in_high;
    op.tag[TAG_LEN-1:0]    = in_tag;
    res                    = mult_sel(op, int'(DATA_LEN));
  end

  assign in_pay          = {res.result[DATA_LEN-1:0], res.ovf, res.tag[TAG_LEN-1:0]};
  assign unused_res_bits = ^{res.result, res.tag};

  // Index 0 is the input port, index PIPELINE_STAGE is the output port.
  logic [PIPELINE_STAGE:0] chain_valid;
  logic [PIPELINE_STAGE:0] chain_ready;
  logic [PayW-1:0]         chain_data [PIPELINE_STAGE+1];

  assign chain_valid[0]              = in_valid;
  assign chain_data[0]               = in_pay;
  assign chain_ready[PIPELINE_STAGE] = out_ready;
  assign in_ready                    = chain_ready[0];
  assign out_valid                   = chain_valid[PIPELINE_STAGE];
  assign {out_result, out_ovf, out_tag} = chain_data[PIPELINE_STAGE];

  for (genvar k = 0; k < PIPELINE_STAGE; k++) begin : g_slot
    mult_slot #(
      .Width (PayW)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .up_valid   (chain_valid[k]),
      .up_ready   (chain_ready[k]),
      .up_data    (chain_data[k]),
      .down_valid (chain_valid[k+1]),
      .down_ready (chain_ready[k+1]),
      .down_data  (chain_data[k+1])
    );
  end

  logic            in_fire;
  logic            out_fire;
  logic [CntW-1:0] inflight_q;
  logic [CntW-1:0] inflight_d;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign inflight = inflight_q;

  always_comb begin
    inflight_d = inflight_q;
    if (in_fire && !out_fire) begin
      inflight_d = inflight_q + CntW'(1);
    end else if (!in_fire && out_fire) begin
      inflight_d = inflight_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_mult_pipe_hs.sv
// Scoreboard bench for mult_pipe_hs: a 3-slot instance under randomized traffic and
// backpressure, plus a 1-slot instance for reset and latency corner cases.
module tb_mult_pipe_hs;

  localparam int DL = 32;
  localparam int TL = 4;
  localparam int NS = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, in_signed, in_high;
  logic [DL-1:0] in_a, in_b;
  logic [TL-1:0] in_tag;
  logic          out_valid, out_ready, out_ovf;
  logic [DL-1:0] out_result;
  logic [TL-1:0] out_tag;
  logic [1:0]    inflight;

  logic          s_in_valid, s_in_ready, s_in_signed, s_in_high;
  logic [DL-1:0] s_in_a, s_in_b;
  logic [TL-1:0] s_in_tag;
  logic          s_out_valid, s_out_ready, s_out_ovf;
  logic [DL-1:0] s_out_result;
  logic [TL-1:0] s_out_tag;
  logic [0:0]    s_inflight;

  mult_pipe_hs #(
    .DATA_LEN       (DL),
    .PIPELINE_STAGE (NS),
    .TAG_LEN        (TL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_signed  (in_signed),
    .in_high    (in_high),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf),
    .out_tag    (out_tag),
    .inflight   (inflight)
  );

  mult_pipe_hs #(
    .DATA_LEN       (DL),
    .PIPELINE_STAGE (1),
    .TAG_LEN        (TL)
  ) dut1 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (s_in_valid),
    .in_ready   (s_in_ready),
    .in_a       (s_in_a),
    .in_b       (s_in_b),
    .in_signed  (s_in_signed),
    .in_high    (s_in_high),
    .in_tag     (s_in_tag),
    .out_valid  (s_out_valid),
    .out_ready  (s_out_ready),
    .out_result (s_out_result),
    .out_ovf    (s_out_ovf),
    .out_tag    (s_out_tag),
    .inflight   (s_inflight)
  );

  typedef struct {
    logic [DL-1:0] result;
    logic          ovf;
    logic [TL-1:0] tag;
    int            cyc;
    bit            lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   acc_cyc = 0;
  int   n_pop = 0;
  bit   lat_mode = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: exact integer product in 64 bits, then pick a half and test representability.
  function automatic logic [DL:0] model(input logic [DL-1:0] a, input logic [DL-1:0] b,
                                        input logic s, input logic h);
    longint ea, eb, p, lim;
    logic [63:0] pu;
    logic [DL-1:0] r;
    logic ovf;
    ea  = s ? longint'($signed(a)) : longint'({32'b0, a});
    eb  = s ? longint'($signed(b)) : longint'({32'b0, b});
    p   = ea * eb;
    pu  = p;
    lim = 64'sd2147483648;
    if (h) begin
      r   = pu[63:32];
      ovf = 1'b0;
    end else begin
      r   = pu[31:0];
      ovf = s ? (p < -lim || p >= lim) : (pu[63:32] != 32'd0);
    end
    return {r, ovf};
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset && in_valid && in_ready) begin
      n_acc++;
      acc_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: actual tag=%0d result=%0h, required no result", out_tag,
                 out_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_pop++;
        chk("result", out_result, e.result);
        chk("ovf", out_ovf, e.ovf);
        chk("tag", out_tag, e.tag);
        if (e.lat) chk("latency_edges", cyc - e.cyc, NS - 1);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DL-1:0] a, input logic [DL-1:0] b, input logic s,
                      input logic h, input logic [TL-1:0] tag, input bit use_exp,
                      input logic [DL-1:0] er, input logic eo);
    int start;
    bit ok;
    logic [DL:0] m;
    exp_t e;
    ok = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_high = h; in_tag = tag;
    start = n_acc;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (n_acc != start) ok = 1'b1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: actual tag %0d not accepted in 60 cycles, required accept",
               tag);
    end else begin
      m        = model(a, b, s, h);
      e.result = use_exp ? er : m[DL:1];
      e.ovf    = use_exp ? eo : m[0];
      e.tag    = tag;
      e.cyc    = acc_cyc;
      e.lat    = lat_mode;
      sb.push_back(e);
    end
  endtask

  task automatic rand_op(input logic [TL-1:0] tag);
    logic [DL-1:0] a, b;
    a = $urandom;
    b = $urandom;
    if ($urandom_range(3) == 0) a = DL'($urandom_range(200)) - 32'd100;
    if ($urandom_range(3) == 0) b = DL'($urandom_range(200)) - 32'd100;
    send(a, b, 1'($urandom_range(1)), 1'($urandom_range(1)), tag, 1'b0, '0, 1'b0);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 100 && sb.size() != 0; i++) step(1);
    chk(nm, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, pop0, cnt;
    logic [DL-1:0] res_hold;
    logic [DL:0]   m;
    in_valid = 1'b1; in_a = 32'd3; in_b = 32'd4; in_signed = 1'b0; in_high = 1'b0; in_tag = '0;
    out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_signed = 1'b0; s_in_high = 1'b0;
    s_in_tag = '0; s_out_ready = 1'b1;

    // Reset held with a request pending
    repeat (4) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_no_accept", n_acc, 0);
    chk("rst_s_out_valid", s_out_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_inflight", inflight, 0);
    step(1);

    // Latency and directed mode vectors
    lat_mode = 1'b1;
    send(32'd7, -32'd3, 1'b1, 1'b0, 4'd5, 1'b1, 32'hFFFFFFEB, 1'b0);
    drain("drain_latency");
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 4'd1, 1'b1, 32'hFFFFFFFE, 1'b0);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 4'd2, 1'b1, 32'h00000001, 1'b1);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 4'd3, 1'b1, 32'h00000001, 1'b0);
    send(32'd7, -32'd3, 1'b1, 1'b1, 4'd4, 1'b1, 32'hFFFFFFFF, 1'b0);
    send(32'h7FFFFFFF, 32'd2, 1'b1, 1'b0, 4'd6, 1'b1, 32'hFFFFFFFE, 1'b1);
    send(32'h80000000, 32'd1, 1'b1, 1'b0, 4'd7, 1'b1, 32'h80000000, 1'b0);
    drain("drain_modes");

    // Backpressure: 10 ops against a stalled consumer
    lat_mode = 1'b0;
    out_ready = 1'b0;
    acc0 = n_acc;
    pop0 = n_pop;
    res_hold = '0;
    fork
      begin
        for (int t = 0; t < 10; t++) rand_op(TL'(t));
      end
      begin
        for (int i = 1; i <= 6; i++) begin
          @(negedge clk);
          if (i == 4) res_hold = out_result;
        end
        chk("bp_accepts", n_acc - acc0, 3);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_inflight", inflight, 3);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_head_tag", out_tag, 0);
        chk("bp_result_stable", out_result, res_hold);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");
    chk("bp_count", n_pop - pop0, 10);

    // Back-to-back random stream
    lat_mode = 1'b1;
    acc0 = n_acc;
    pop0 = n_pop;
    fork
      begin
        for (int t = 0; t < 100; t++) rand_op(TL'(t));
      end
      begin
        for (int i = 0; i < 20 && (n_acc - acc0) < 4; i++) @(negedge clk);
        chk("stream_started", (n_acc - acc0) >= 4, 1);
        repeat (80) begin
          @(negedge clk);
          chk("stream_inflight", inflight, 3);
        end
      end
    join
    drain("drain_stream");
    chk("stream_count", n_pop - pop0, 100);
    lat_mode = 1'b0;

    // Reset with a full pipeline
    out_ready = 1'b0;
    for (int t = 0; t < 3; t++) rand_op(TL'(t));
    chk("pre_rst_inflight", inflight, 3);
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_inflight", inflight, 0);
    sb.delete();
    pop0 = n_pop;
    step(1);
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_stale", n_pop, pop0);
    step(1);
    send(32'd1000, 32'd1000, 1'b0, 1'b0, 4'd11, 1'b1, 32'd1000000, 1'b0);
    drain("drain_after_rst");
    chk("after_rst_count", n_pop - pop0, 1);

    // One-slot instance: hold, reset, then latency 1
    s_out_ready = 1'b0;
    s_in_valid = 1'b1; s_in_a = 32'd12345; s_in_b = -32'd77; s_in_signed = 1'b1; s_in_tag = 4'd9;
    step(1);
    s_in_valid = 1'b0;
    m = model(32'd12345, -32'd77, 1'b1, 1'b0);
    @(negedge clk);
    chk("n1_held_valid", s_out_valid, 1);
    chk("n1_held_inflight", s_inflight, 1);
    chk("n1_held_result", s_out_result, m[DL:1]);
    chk("n1_held_tag", s_out_tag, 9);
    step(1);
    reset = 1'b0;
    #1;
    chk("n1_rst_valid", s_out_valid, 0);
    chk("n1_rst_inflight", s_inflight, 0);
    step(1);
    reset = 1'b1;
    s_out_ready = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (s_out_valid) cnt++;
    end
    chk("n1_no_stale", cnt, 0);
    step(1);
    s_in_valid = 1'b1; s_in_a = 32'hFFFFFFFF; s_in_b = 32'h2; s_in_signed = 1'b0; s_in_tag = 4'd3;
    step(1);
    s_in_valid = 1'b0;
    m = model(32'hFFFFFFFF, 32'h2, 1'b0, 1'b0);
    @(negedge clk);
    chk("n1_lat_valid", s_out_valid, 1);
    chk("n1_lat_result", s_out_result, m[DL:1]);
    chk("n1_lat_ovf", s_out_ovf, m[0]);
    chk("n1_lat_tag", s_out_tag, 3);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
